// File: rtl/carry_skip_pkg.sv
// Shared constants and stage payload type for the pipelined carry-skip adder.
package carry_skip_pkg;

    localparam int unsigned CSA_WIDTH = 16;
    localparam int unsigned CSA_BLOCK = 4;

    // Per-stage carry state travelling alongside the operand/sum words.
    typedef struct packed {
        logic carry;
        logic ovf;
    } stage_ctl_t;

endpackage

// File: rtl/carry_skip_block.sv
// One BLOCK-bit carry-skip slice: ripple sum plus a skip mux on the carry-out.
module carry_skip_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_prop,
    output logic             o_c_msb
);

    always_comb begin
        logic [BLOCK:0] w_c;
        w_c     = '0;
        o_sum   = '0;
        w_c[0]  = i_cin;
        for (int i = 0; i < int'(BLOCK); i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_c[i]);
        end
        o_prop  = &(i_a ^ i_b);
        // Skip path: a fully propagating slice passes its carry-in straight through.
        o_cout  = o_prop ? i_cin : w_c[BLOCK];
        o_c_msb = w_c[BLOCK-1];
    end

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder: one BLOCK-bit slice per stage, valid/ready flow
// control with bubble collapsing and a registered result at the last stage.
module carry_skip_adder_pipe
    import carry_skip_pkg::*;
#(
    parameter int unsigned WIDTH = CSA_WIDTH,
    parameter int unsigned BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NBLK = (BLOCK == 0) ? 1 : WIDTH / BLOCK;
    localparam int unsigned REM  = (BLOCK == 0) ? 0 : WIDTH % BLOCK;
    localparam int unsigned LAST = NBLK - 1;

    generate
        if (BLOCK < 1 || WIDTH < 2 || REM != 0) begin : g_bad_params
            $error("carry_skip_adder_pipe: WIDTH must be >= 2 and a multiple of BLOCK >= 1");
        end
    endgenerate

    // Stage registers: stage k holds operands with slices [0..k] already summed.
    logic [WIDTH-1:0] r_a   [NBLK];
    logic [WIDTH-1:0] r_b   [NBLK];
    logic [WIDTH-1:0] r_s   [NBLK];
    stage_ctl_t       r_ctl [NBLK];
    logic             r_v   [NBLK];

    logic [WIDTH-1:0] w_src_a   [NBLK];
    logic [WIDTH-1:0] w_src_b   [NBLK];
    logic [WIDTH-1:0] w_src_s   [NBLK];
    logic [WIDTH-1:0] w_nxt_s   [NBLK];
    logic [BLOCK-1:0] w_blk_s   [NBLK];
    stage_ctl_t       w_nxt_ctl [NBLK];
    logic             w_src_v   [NBLK];
    logic             w_adv     [NBLK];
    logic [NBLK-1:0]  w_src_c;
    logic [NBLK-1:0]  w_co;
    logic [NBLK-1:0]  w_prop;
    logic [NBLK-1:0]  w_cmsb;

    generate
        for (genvar k = 0; k < int'(NBLK); k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_src_a[k] = a;
                assign w_src_b[k] = b;
                assign w_src_s[k] = '0;
                assign w_src_c[k] = cin;
                assign w_src_v[k] = in_valid;
            end else begin : g_body
                assign w_src_a[k] = r_a[k-1];
                assign w_src_b[k] = r_b[k-1];
                assign w_src_s[k] = r_s[k-1];
                assign w_src_c[k] = r_ctl[k-1].carry;
                assign w_src_v[k] = r_v[k-1];
            end

            carry_skip_block #(
                .BLOCK (BLOCK)
            ) u_blk (
                .i_a     (w_src_a[k][k*BLOCK +: BLOCK]),
                .i_b     (w_src_b[k][k*BLOCK +: BLOCK]),
                .i_cin   (w_src_c[k]),
                .o_sum   (w_blk_s[k]),
                .o_cout  (w_co[k]),
                .o_prop  (w_prop[k]),
                .o_c_msb (w_cmsb[k])
            );

            // Slice k of the incoming sum word is still zero, so OR merges it in.
            assign w_nxt_s[k]         = w_src_s[k] | (WIDTH'(w_blk_s[k]) << (k*BLOCK));
            assign w_nxt_ctl[k].carry = w_co[k];
            // A fully propagating slice cannot overflow: MSB carry-in equals carry-out.
            assign w_nxt_ctl[k].ovf   = ~w_prop[k] & (w_cmsb[k] ^ w_co[k]);
        end
    endgenerate

    // Advance chain from the output back: a stage moves if empty or its successor moves.
    always_comb begin
        logic w_chain;
        for (int k = 0; k < int'(NBLK); k++) begin
            w_adv[k] = 1'b0;
        end
        w_chain     = ~r_v[LAST] | out_ready;
        w_adv[LAST] = w_chain;
        for (int k = int'(NBLK) - 2; k >= 0; k--) begin
            w_chain  = ~r_v[k] | w_chain;
            w_adv[k] = w_chain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NBLK); k++) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_ctl[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NBLK); k++) begin
                if (w_adv[k]) begin
                    r_v[k]   <= w_src_v[k];
                    r_a[k]   <= w_src_a[k];
                    r_b[k]   <= w_src_b[k];
                    r_s[k]   <= w_nxt_s[k];
                    r_ctl[k] <= w_nxt_ctl[k];
                end
            end
        end
    end

    assign in_ready  = w_adv[0] & ~rst;
    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_ctl[LAST].carry;
    assign ovf       = r_ctl[LAST].ovf;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Randomised and directed bench for carry_skip_adder_pipe (WIDTH=16, BLOCK=4).
module tb_carry_skip_adder_pipe;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [17:0] exp_q [$];

    logic [15:0] dv_a  [6] = '{16'hFFFF, 16'hAAAA, 16'hAAAA, 16'h7FFF, 16'h8000, 16'h1234};
    logic [15:0] dv_b  [6] = '{16'h0001, 16'h5555, 16'h5555, 16'h0001, 16'h8000, 16'h4321};
    logic        dv_c  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] dv_s  [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'h5556};
    logic        dv_co [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        dv_ov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    carry_skip_adder_pipe #(
        .WIDTH (16),
        .BLOCK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [31:0] t;
        logic [15:0] s;
        logic        v;
        t = 32'(x) + 32'(y) + 32'(c);
        s = t[15:0];
        v = (x[15] == y[15]) && (s[15] != x[15]);
        return {t[16], v, s};
    endfunction

    task automatic drive_rand();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got %h want 0000", sum); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        int  lat;
        bit  found;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 a = dv_a[i]; b = dv_b[i]; cin = dv_c[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 1; found = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (out_valid === 1'b1) begin found = 1'b1; break; end
                @(posedge clk);
                lat++;
            end
            n_vec++;
            if (!found) begin
                n_err++; $display("FAIL dir%0d_timeout got no out_valid want latency %0d", i, NB);
            end else begin
                if (lat != NB) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NB); end
                n_vec++;
                if ({cout, ovf, sum} !== {dv_co[i], dv_ov[i], dv_s[i]}) begin
                    n_err++;
                    $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             i, sum, cout, ovf, dv_s[i], dv_co[i], dv_ov[i]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first_acc = -1, first_out = -1, last_out = -1;
        logic [17:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int t = 0; t < 40 && got < 8; t++) begin
            in_valid = (sent < 8);
            if (sent < 8) drive_rand();
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
                n_vec++;
                if ({cout, ovf, sum} !== e) begin n_err++; $display("FAIL b2b_result got %h want %h", {cout, ovf, sum}, e); end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", got); end
        n_vec++; if (first_out - first_acc != NB) begin n_err++; $display("FAIL b2b_first_latency got %0d want %0d", first_out - first_acc, NB); end
        n_vec++; if (last_out - first_out != 7) begin n_err++; $display("FAIL b2b_consecutive got span %0d want 7", last_out - first_out); end
    endtask

    task automatic test_backpressure();
        int   sent = 0, got = 0;
        bit   saw_full = 1'b0, prev_stall = 1'b0, exp_rdy;
        logic [17:0] held = '0, e;
        exp_q.delete();
        for (int t = 0; t < 80 && (sent < 16 || exp_q.size() > 0); t++) begin
            in_valid  = (sent < 16);
            if (sent < 16) drive_rand();
            out_ready = !(t >= 8 && t < 14);
            @(negedge clk);
            exp_rdy = out_ready || (exp_q.size() < NB);
            n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready t=%0d got %b want %b", t, in_ready, exp_rdy); end
            if (in_ready === 1'b0) saw_full = 1'b1;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || {cout, ovf, sum} !== held) begin
                    n_err++; $display("FAIL bp_hold t=%0d got v=%b %h want v=1 %h", t, out_valid, {cout, ovf, sum}, held);
                end
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 18'h3FFFF;
                n_vec++; if ({cout, ovf, sum} !== e) begin n_err++; $display("FAIL bp_result t=%0d got %h want %h", t, {cout, ovf, sum}, e); end
                if (out_ready && exp_q.size() > 0) begin void'(exp_q.pop_front()); got++; end
            end
            prev_stall = out_valid && !out_ready;
            held       = {cout, ovf, sum};
            if (in_valid && in_ready) begin exp_q.push_back(model(a, b, cin)); sent++; end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (!saw_full) begin n_err++; $display("FAIL bp_in_ready_fall got never-low want low while stalled"); end
        n_vec++; if (got != 16) begin n_err++; $display("FAIL bp_count got %0d want 16", got); end
    endtask

    task automatic test_reset_midstream();
        int ghosts = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; drive_rand();
            @(posedge clk);
            #1;
        end
        rst = 1'b1; in_valid = 1'b1; drive_rand();
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        n_vec++; if ({cout, ovf, sum} !== 18'h0) begin n_err++; $display("FAIL rstmid_outputs got %h want 0", {cout, ovf, sum}); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ghosts++;
        end
        n_vec++; if (ghosts != 0) begin n_err++; $display("FAIL rstmid_ghost got %0d results want 0", ghosts); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int   sent = 0, got = 0;
        bit   prev_stall = 1'b0, exp_rdy;
        logic [17:0] held = '0, e;
        exp_q.delete();
        for (int t = 0; t < 20000 && (sent < 1000 || exp_q.size() > 0); t++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            drive_rand();
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            exp_rdy = out_ready || (exp_q.size() < NB);
            if (in_ready !== exp_rdy) begin n_vec++; n_err++; $display("FAIL rnd_in_ready t=%0d got %b want %b", t, in_ready, exp_rdy); end
            if (prev_stall && (out_valid !== 1'b1 || {cout, ovf, sum} !== held)) begin
                n_vec++; n_err++; $display("FAIL rnd_hold t=%0d got v=%b %h want v=1 %h", t, out_valid, {cout, ovf, sum}, held);
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
                n_vec++; if ({cout, ovf, sum} !== e) begin n_err++; $display("FAIL rnd_result #%0d got %h want %h", got, {cout, ovf, sum}, e); end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            held       = {cout, ovf, sum};
            if (in_valid && in_ready) begin exp_q.push_back(model(a, b, cin)); sent++; end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (got != 1000) begin n_err++; $display("FAIL rnd_count got %0d want 1000", got); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
